sha3_padder_gen: RTL

- Parametrised successor to the fixed 32-bit/576-bit Keccak input padder.
- Collects IN_W-bit message words into a RATE-bit block and applies multi-rate padding with a configurable domain suffix: 0x06 for SHA3, 0x01 for legacy Keccak, 0x1F for SHAKE.
- Hands each full block to the f-permutation through a ready/ack handshake.
- Sits between the host word interface and the permutation core; handles back-to-back messages without reset.

---
 rtl/sha3_padder_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sha3_padder_gen.sv
// Purpose: packs IN_W-bit message words into a RATE-bit block and applies Keccak multi-rate padding with a domain suffix.
// Latency: out_ready rises on the edge loading the last block word; a short final word adds one PAD edge per missing word.
// Backpressure: buffer_full is high outside ACCEPT; the source holds its word until it drops, and FULL holds until f_ack.
module sha3_padder_gen #(
  parameter int         IN_W   = 32,
  parameter int         RATE   = 576,
  parameter logic [7:0] SUFFIX = 8'h06
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IN_W-1:0]             in,
  input  logic                        in_ready,
  input  logic                        is_last,
  input  logic [$clog2(IN_W/8)-1:0]   byte_num,
  output logic                        buffer_full,
  output logic [RATE-1:0]             out,
  output logic                        out_ready,
  output logic                        out_last,
  input  logic                        f_ack
);

  localparam int NB    = IN_W / 8;
  localparam int WORDS = RATE / IN_W;
  localparam int CW    = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  // Elaboration-time guards on the supported geometry.
  if (!(IN_W == 32 || IN_W == 64)) begin : g_bad_in_w
    $error("sha3_padder_gen: IN_W must be 32 or 64");
  end
  if ((RATE % IN_W) != 0 || WORDS < 2) begin : g_bad_rate
    $error("sha3_padder_gen: RATE must be a multiple of IN_W holding at least two words");
  end

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_PAD    = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [RATE-1:0] r_out;
  logic            r_out_last;

  logic            w_at_last;
  logic            w_shift;
  logic            w_clear;
  logic            w_last_nxt;
  logic [IN_W-1:0] w_word;
  logic [IN_W-1:0] w_final;

  // The word about to be loaded is the one that completes the block.
  assign w_at_last = (r_count == LAST_IDX);

  // Final-word shaping: keep the valid MSB-side bytes, drop the suffix right after them,
  // zero the rest, and close the padding with 0x80 if this word also ends the block.
  always_comb begin
    w_final = '0;
    for (int k = 0; k < NB; k++) begin
      if (k < int'(byte_num)) begin
        w_final[IN_W-1-8*k -: 8] = in[IN_W-1-8*k -: 8];
      end else if (k == int'(byte_num)) begin
        w_final[IN_W-1-8*k -: 8] = SUFFIX;
      end
    end
    if (w_at_last) begin
      w_final[7:0] = w_final[7:0] | 8'h80;
    end
  end

  // Next-state logic and datapath controls for the ACCEPT / PAD / FULL sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_word      = '0;
    w_last_nxt  = r_out_last;
    case (r_state)
      S_ACCEPT: begin
        if (in_ready) begin
          w_shift = 1'b1;
          w_word  = is_last ? w_final : in;
          if (w_at_last) begin
            w_state_nxt = S_FULL;
            w_last_nxt  = is_last;
          end else if (is_last) begin
            w_state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        // Zero filler words; the one that completes the block carries the closing 0x80.
        w_shift = 1'b1;
        if (w_at_last) begin
          w_word[7:0] = 8'h80;
          w_state_nxt = S_FULL;
          w_last_nxt  = 1'b1;
        end
      end
      S_FULL: begin
        // Any word offered alongside the ack waits for the next cycle.
        if (f_ack) begin
          w_clear     = 1'b1;
          w_state_nxt = S_ACCEPT;
          w_last_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_ACCEPT;
        w_clear     = 1'b1;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Block shift register, word counter and last-block flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out      <= '0;
      r_count    <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_out_last <= w_last_nxt;
      if (w_clear) begin
        r_out   <= '0;
        r_count <= '0;
      end else if (w_shift) begin
        r_out   <= {r_out[RATE-IN_W-1:0], w_word};
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign buffer_full = (r_state != S_ACCEPT);
  assign out_ready   = (r_state == S_FULL);
  assign out         = r_out;
  assign out_last    = r_out_last;

endmodule
